// File: rtl/cjtag_bridge.sv
// Target-side cJTAG (OScan1) to 4-wire JTAG bridge.
// TCKC/TMSC are oversampled on CLK; escapes, activation and 3-phase packets are decoded here.
//
// state    | meaning
// OFFLINE  | deselected; JTAG outputs parked, only escapes acted on
// ACTIVATE | shifting the 12-bit OAC/EC/CP activation code, LSB first
// OSCAN1   | online; nTDI / TMS / TDO packets decoded on a 3-phase cycle
module cjtag_bridge #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] ACT_CODE    = 12'b0000_1000_1100,
  parameter int          ESC_CNT_W   = 4
) (
  input  logic CLK,
  input  logic RES,
  input  logic TCKC_I,
  input  logic TMSC_I,
  output logic TMSC_O,
  output logic TMSC_E,
  output logic TCK,
  output logic TMS,
  output logic TDI,
  input  logic TDO,
  output logic TAP_RESET,
  output logic ONLINE
);

  typedef enum logic [1:0] {
    OFFLINE  = 2'd0,
    ACTIVATE = 2'd1,
    OSCAN1   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] tckc_sync;
  logic [SYNC_STAGES-1:0] tmsc_sync;
  logic                   tckc_d;
  logic                   tmsc_d;
  logic                   tckc_s;
  logic                   tmsc_s;
  logic                   tckc_rise;
  logic                   tckc_fall;
  logic                   tmsc_edge;
  logic [SYNC_STAGES:0]   drv_pipe;
  logic                   drv_mask;
  logic [ESC_CNT_W-1:0]   esc_cnt;
  int unsigned            esc_val;

  state_t      state, state_nxt;
  logic [1:0]  phase, phase_nxt;
  logic [3:0]  shcnt, shcnt_nxt;
  logic [11:0] shreg, shreg_nxt;
  logic        tck_nxt;
  logic        tms_nxt;
  logic        tdi_nxt;
  logic        tmsc_o_nxt;
  logic        tmsc_e_nxt;
  logic        tap_reset_nxt;

  assign tckc_s    = tckc_sync[SYNC_STAGES-1];
  assign tmsc_s    = tmsc_sync[SYNC_STAGES-1];
  assign tckc_rise = tckc_s & ~tckc_d;
  assign tckc_fall = ~tckc_s & tckc_d;
  assign tmsc_edge = tmsc_s ^ tmsc_d;
  // our own drive reaches the edge detector late, so mask it for the sync latency
  assign drv_mask  = TMSC_E | (|drv_pipe);
  assign ONLINE    = (state == OSCAN1);

  always_ff @(posedge CLK) begin
    if (RES) begin
      tckc_sync <= '0;
      tmsc_sync <= '0;
      tckc_d    <= 1'b0;
      tmsc_d    <= 1'b0;
      drv_pipe  <= '0;
    end else begin
      tckc_sync <= {tckc_sync[SYNC_STAGES-2:0], TCKC_I};
      tmsc_sync <= {tmsc_sync[SYNC_STAGES-2:0], TMSC_I};
      tckc_d    <= tckc_s;
      tmsc_d    <= tmsc_s;
      drv_pipe  <= {drv_pipe[SYNC_STAGES-1:0], TMSC_E};
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      esc_cnt <= '0;
    end else if (tckc_rise || tckc_fall) begin
      esc_cnt <= '0;
    end else if (tckc_s && tmsc_edge && !drv_mask && (esc_cnt != '1)) begin
      esc_cnt <= esc_cnt + ESC_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state     <= OFFLINE;
      phase     <= 2'd0;
      shcnt     <= 4'd0;
      shreg     <= 12'd0;
      TCK       <= 1'b0;
      TMS       <= 1'b1;
      TDI       <= 1'b1;
      TMSC_O    <= 1'b0;
      TMSC_E    <= 1'b0;
      TAP_RESET <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      shcnt     <= shcnt_nxt;
      shreg     <= shreg_nxt;
      TCK       <= tck_nxt;
      TMS       <= tms_nxt;
      TDI       <= tdi_nxt;
      TMSC_O    <= tmsc_o_nxt;
      TMSC_E    <= tmsc_e_nxt;
      TAP_RESET <= tap_reset_nxt;
    end
  end

  always_comb begin
    esc_val       = 32'(esc_cnt);
    state_nxt     = state;
    phase_nxt     = phase;
    shcnt_nxt     = shcnt;
    shreg_nxt     = shreg;
    tck_nxt       = TCK;
    tms_nxt       = TMS;
    tdi_nxt       = TDI;
    tmsc_o_nxt    = TMSC_O;
    tmsc_e_nxt    = TMSC_E;
    tap_reset_nxt = 1'b0;

    // an escape seen at TCKC fall overrides any phase fall action
    if (tckc_fall && (esc_val != 0)) begin
      if (esc_val <= 3) begin
        phase_nxt  = 2'd0;
        tmsc_e_nxt = 1'b0;
      end else if (esc_val <= 5) begin
        state_nxt = OFFLINE;
      end else if (esc_val <= 7) begin
        state_nxt = ACTIVATE;
        shcnt_nxt = 4'd0;
      end else begin
        state_nxt     = OFFLINE;
        tap_reset_nxt = 1'b1;
      end
    end else begin
      case (state)
        ACTIVATE: begin
          if (tckc_rise) begin
            shreg_nxt = {tmsc_s, shreg[11:1]};
            shcnt_nxt = shcnt + 4'd1;
            if (shcnt == 4'd11) begin
              if (shreg_nxt == ACT_CODE) begin
                state_nxt = OSCAN1;
                phase_nxt = 2'd0;
              end else begin
                state_nxt = OFFLINE;
              end
            end
          end
        end
        OSCAN1: begin
          if (tckc_rise) begin
            case (phase)
              2'd0: begin
                tdi_nxt   = ~tmsc_s;
                tck_nxt   = 1'b0;
                phase_nxt = 2'd1;
              end
              2'd1: begin
                tms_nxt   = tmsc_s;
                phase_nxt = 2'd2;
              end
              default: begin
                tck_nxt   = 1'b1;
                phase_nxt = 2'd0;
              end
            endcase
          end else if (tckc_fall) begin
            // phase holds the next rise's phase: 2 means we are in phase 1 low, 0 in phase 2 low
            if (phase == 2'd2) begin
              tmsc_e_nxt = 1'b1;
              tmsc_o_nxt = TDO;
            end else if (phase == 2'd0) begin
              tmsc_e_nxt = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end

    if (state_nxt != OSCAN1) begin
      tck_nxt    = 1'b0;
      tms_nxt    = 1'b1;
      tmsc_e_nxt = 1'b0;
    end
  end

endmodule
